vector_sweep_checker: RTL



---
 rtl/vector_sweep_checker.sv | 112 +++++++++++
 1 files changed

// File: rtl/vector_sweep_checker.sv
// vector_sweep_checker: sweeps every N_IN-bit vector, holds each for HOLD
// clocks and compares DUT against golden outputs on the last hold cycle.
// Ports: clk, rst_n (async, active-low), start, dut_out, exp_out -> vec,
//   busy, done (pulse), pass, err_count (saturating), fail_seen,
//   first_fail_vec.
// Option: define VSC_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module vector_sweep_checker #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int HOLD  = 10,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] exp_out,
    output logic [N_IN-1:0]  vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_seen,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam int HW = 16;

`ifdef VSC_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic            mismatch;
    logic            last_hold;
    logic            end_sweep;
    logic [ERR_W-1:0] err_next;

    assign mismatch  = (dut_out != exp_out);
    assign last_hold = (hold_cnt == HW'(HOLD - 1));
    // Sweep ends after the all-ones vector, or at the first miss when stopping.
    assign end_sweep = (&vec) || (STOP && mismatch);
    assign err_next  = (&err_count) ? err_count
                                    : err_count + ERR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
            hold_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec            <= '0;
                        hold_cnt       <= '0;
                        err_count      <= '0;
                        fail_seen      <= 1'b0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    hold_cnt <= hold_cnt + HW'(1);
                    if (last_hold) begin
                        if (mismatch) begin
                            err_count <= err_next;
                            if (!fail_seen) begin
                                first_fail_vec <= vec;
                                fail_seen      <= 1'b1;
                            end
                        end
                        if (end_sweep) begin
                            // done/pass land together so the final
                            // compare is already reflected when done rises
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (err_count == '0) && !mismatch;
                        end else begin
                            vec      <= vec + N_IN'(1);
                            hold_cnt <= '0;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
